// File: rtl/eth_rx_payload_extract.sv
// MII RX payload extractor: preamble/SFD detect, header skip, nibble-to-byte assembly, FCS strip.
// Optional CRC-32 frame check when CRC_CHECK_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for first preamble nibble
// S_PREAMBLE | receiving 0x5 nibbles, waiting for SFD (0xD)
// S_HEADER   | skipping HDR_BYTES header bytes
// S_PAYLOAD  | assembling bytes through the 4-byte FCS delay line
// S_DROP     | malformed preamble, ignore until RX_DV falls
module eth_rx_payload_extract #(
  parameter int HDR_BYTES = 42,
  parameter int LEN_W     = 11
) (
  input  logic             eth_clk,
  input  logic             rst,
  input  logic [3:0]       nibble,
  input  logic             nibble_valid,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             data_first,
  output logic             frame_done,
  output logic             frame_err,
  output logic [LEN_W-1:0] payload_len
);

  localparam int              HC_W     = $clog2(HDR_BYTES + 1);
  localparam logic [HC_W-1:0] HDR_LAST = HC_W'(HDR_BYTES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t            state, state_next;
  logic              phase;
  logic [3:0]        low_nib;
  logic [HC_W-1:0]   hdr_cnt;
  logic [7:0]        dl [4];
  logic [2:0]        dl_cnt;
  logic [LEN_W-1:0]  len_cnt;
  logic              first_pend;

  logic              sfd;
  logic              byte_done;
  logic              eof;
  logic              in_frame;
  logic              push;
  logic              emit;
  logic              len_err;
  logic              crc_bad;
  logic [7:0]        cur_byte;

  assign in_frame = (state == S_HEADER) || (state == S_PAYLOAD);
  assign cur_byte = {nibble, low_nib};
  assign push     = byte_done && (state == S_PAYLOAD);
  assign emit     = push && (dl_cnt == 3'd4);
  assign len_err  = phase || (state == S_HEADER) || (dl_cnt != 3'd4);

  always_comb begin
    state_next = state;
    sfd        = 1'b0;
    byte_done  = 1'b0;
    eof        = 1'b0;
    case (state)
      S_IDLE: begin
        if (nibble_valid)
          state_next = (nibble == 4'h5) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!nibble_valid) begin
          state_next = S_IDLE;
        end else if (nibble == 4'hD) begin
          state_next = S_HEADER;
          sfd        = 1'b1;
        end else if (nibble != 4'h5) begin
          state_next = S_DROP;
        end
      end
      S_HEADER: begin
        if (!nibble_valid) begin
          eof        = 1'b1;
          state_next = S_IDLE;
        end else if (phase) begin
          byte_done = 1'b1;
          if (hdr_cnt == '0)
            state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!nibble_valid) begin
          eof        = 1'b1;
          state_next = S_IDLE;
        end else if (phase) begin
          byte_done = 1'b1;
        end
      end
      S_DROP: begin
        if (!nibble_valid)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CRC_CHECK_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  logic [31:0] crc, crc_upd;

  // Reflected CRC, one nibble per cycle, LSB first; no final inversion so the
  // register lands on the fixed residue when the FCS is included.
  always_comb begin
    crc_upd = crc;
    for (int i = 0; i < 4; i++) begin
      if (crc_upd[0] ^ nibble[i])
        crc_upd = (crc_upd >> 1) ^ CRC_POLY;
      else
        crc_upd = crc_upd >> 1;
    end
  end

  always_ff @(posedge eth_clk) begin
    if (rst)
      crc <= '1;
    else if (sfd)
      crc <= '1;
    else if (in_frame && nibble_valid)
      crc <= crc_upd;
  end

  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge eth_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      low_nib     <= '0;
      hdr_cnt     <= '0;
      dl_cnt      <= '0;
      len_cnt     <= '0;
      first_pend  <= 1'b0;
      for (int i = 0; i < 4; i++) dl[i] <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      data_first  <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      payload_len <= '0;
    end else begin
      state      <= state_next;
      data_valid <= 1'b0;
      data_first <= 1'b0;
      frame_done <= 1'b0;

      if (sfd) begin
        phase      <= 1'b0;
        hdr_cnt    <= HDR_LAST;
        dl_cnt     <= '0;
        len_cnt    <= '0;
        first_pend <= 1'b1;
      end

      if (in_frame && nibble_valid) begin
        phase <= ~phase;
        if (!phase)
          low_nib <= nibble;
      end

      if (byte_done && (state == S_HEADER) && (hdr_cnt != '0))
        hdr_cnt <= hdr_cnt - 1'b1;

      // Oldest entry lives in dl[3]; it leaves only when a newer byte proves it is not FCS.
      if (push) begin
        dl[3] <= dl[2];
        dl[2] <= dl[1];
        dl[1] <= dl[0];
        dl[0] <= cur_byte;
        if (dl_cnt != 3'd4)
          dl_cnt <= dl_cnt + 3'd1;
      end

      if (emit) begin
        data       <= dl[3];
        data_valid <= 1'b1;
        data_first <= first_pend;
        first_pend <= 1'b0;
        if (len_cnt != LEN_MAX)
          len_cnt <= len_cnt + LEN_W'(1);
      end

      if (eof) begin
        frame_done  <= 1'b1;
        frame_err   <= len_err || crc_bad;
        payload_len <= len_err ? '0 : len_cnt;
        dl_cnt      <= '0;
        phase       <= 1'b0;
        first_pend  <= 1'b0;
      end
    end
  end

endmodule
